// File: rtl/compositor_pkg.sv
// Shared types for the sprite compositor: per-layer configuration record,
// layer shape kind and the fixed pixel pipeline latency.
package compositor_pkg;

  localparam int PIPE_LAT    = 3;
  localparam int PKG_COORD_W = 10;
  localparam int PKG_IDX_W   = 8;

  typedef enum logic {
    LK_RECT   = 1'b0,
    LK_CIRCLE = 1'b1
  } layer_kind_e;

  typedef struct packed {
    logic                   en;
    layer_kind_e            kind;
    logic [PKG_COORD_W-1:0] x;
    logic [PKG_COORD_W-1:0] y;
    logic [PKG_COORD_W-1:0] w;
    logic [PKG_COORD_W-1:0] h;
    logic [PKG_IDX_W-1:0]   color;
  } layer_cfg_t;

endpackage

// File: rtl/layer_hit.sv
// Combinational hit test of one layer against the current pixel; also gives
// the texture-local coordinates (tiling modulo the texture size).
module layer_hit
  import compositor_pkg::*;
#(
  parameter int TEX_W = 5
) (
  input  layer_cfg_t             cfg,
  input  logic [PKG_COORD_W-1:0] draw_x,
  input  logic [PKG_COORD_W-1:0] draw_y,
  output logic                   hit,
  output logic [TEX_W-1:0]       rel_x,
  output logic [TEX_W-1:0]       rel_y,
  output logic [PKG_IDX_W-1:0]   color
);

  localparam int CW = PKG_COORD_W;

  logic [CW:0]            x_end_s, y_end_s;
  logic                   rect_hit_s, circ_hit_s;
  logic signed [CW:0]     dx_s, dy_s;
  logic signed [2*CW+1:0] dx2_s, dy2_s;
  logic [2*CW+1:0]        d2_s, r2_s;

  // Rectangle and circle membership; one extra bit on sums keeps edges from wrapping.
  always_comb begin
    x_end_s    = {1'b0, cfg.x} + {1'b0, cfg.w};
    y_end_s    = {1'b0, cfg.y} + {1'b0, cfg.h};
    rect_hit_s = (draw_x >= cfg.x) && ({1'b0, draw_x} < x_end_s) &&
                 (draw_y >= cfg.y) && ({1'b0, draw_y} < y_end_s);
    dx_s       = $signed({1'b0, draw_x}) - $signed({1'b0, cfg.x});
    dy_s       = $signed({1'b0, draw_y}) - $signed({1'b0, cfg.y});
    dx2_s      = $signed({{(CW+1){dx_s[CW]}}, dx_s}) * $signed({{(CW+1){dx_s[CW]}}, dx_s});
    dy2_s      = $signed({{(CW+1){dy_s[CW]}}, dy_s}) * $signed({{(CW+1){dy_s[CW]}}, dy_s});
    d2_s       = $unsigned(dx2_s + dy2_s);
    r2_s       = {{(CW+2){1'b0}}, cfg.w} * {{(CW+2){1'b0}}, cfg.w};
    circ_hit_s = (d2_s <= r2_s);
    case (cfg.kind)
      LK_RECT:   hit = cfg.en && rect_hit_s;
      LK_CIRCLE: hit = cfg.en && circ_hit_s;
      default:   hit = 1'b0;
    endcase
    rel_x = TEX_W'(draw_x - cfg.x);
    rel_y = TEX_W'(draw_y - cfg.y);
    color = cfg.color;
  end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage layer compositor: hit test -> texture/colour select -> palette.
// Optional collision outputs are built when COMPOSITOR_COLLISION_EN is defined.
module sprite_compositor
  import compositor_pkg::*;
#(
  parameter int  NUM_LAYERS = 4,
  parameter int  COORD_W    = PKG_COORD_W,
  parameter int  TEX_W      = 5,
  parameter int  IDX_W      = PKG_IDX_W,
  localparam int SEL_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int TA_W       = SEL_W + 2*TEX_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic               pix_valid_in,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               cfg_we,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic               cfg_en,
  input  logic               cfg_kind,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic [COORD_W-1:0] cfg_h,
  input  logic [IDX_W-1:0]   cfg_color,
  input  logic               pal_we,
  input  logic [IDX_W-1:0]   pal_addr,
  input  logic [23:0]        pal_rgb,
  input  logic [23:0]        bg_rgb,
  output logic [TA_W-1:0]    tex_addr,
  input  logic [IDX_W-1:0]   tex_idx,
  output logic               pix_valid_out,
  output logic [7:0]         Red,
  output logic [7:0]         Green,
  output logic [7:0]         Blue
`ifdef COMPOSITOR_COLLISION_EN
  ,
  output logic [NUM_LAYERS-1:0] hit_mask,
  output logic [NUM_LAYERS-1:0] collide
`endif
);

  layer_cfg_t        shadow_q [NUM_LAYERS];
  layer_cfg_t        shadow_d [NUM_LAYERS];
  layer_cfg_t        active_q [NUM_LAYERS];
  layer_cfg_t        active_d [NUM_LAYERS];
  logic [23:0]       pal_q    [2**IDX_W];
  logic [23:0]       pal_d    [2**IDX_W];

  logic [NUM_LAYERS-1:0] hit_s;
  logic [TEX_W-1:0]      rel_x_s [NUM_LAYERS];
  logic [TEX_W-1:0]      rel_y_s [NUM_LAYERS];
  logic [IDX_W-1:0]      color_s [NUM_LAYERS];
  logic [SEL_W-1:0]      win_s;
  logic                  any_hit_s;
  logic [IDX_W-1:0]      idx_s;

  logic              v1_q, v1_d, hit1_q, hit1_d, circ1_q, circ1_d;
  logic [IDX_W-1:0]  color1_q, color1_d;
  logic [TA_W-1:0]   tex_addr_q, tex_addr_d;
  logic              v2_q, v2_d, hit2_q, hit2_d, circ2_q, circ2_d;
  logic [IDX_W-1:0]  color2_q, color2_d;
  logic              valid_out_q, valid_out_d;
  logic [23:0]       rgb_q, rgb_d;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_hit
    layer_hit #(.TEX_W(TEX_W)) u_layer_hit (
      .cfg    (active_q[g]),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .hit    (hit_s[g]),
      .rel_x  (rel_x_s[g]),
      .rel_y  (rel_y_s[g]),
      .color  (color_s[g])
    );
  end

  // Shadow writes, frame-boundary shadow-to-active copy, palette writes.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we && (32'(cfg_sel) < 32'(NUM_LAYERS))) begin
      shadow_d[cfg_sel] = '{en: cfg_en, kind: layer_kind_e'(cfg_kind), x: cfg_x, y: cfg_y,
                            w: cfg_w, h: cfg_h, color: cfg_color};
    end else begin
      shadow_d = shadow_q;
    end
    if (frame_start) begin
      active_d = shadow_d;
    end else begin
      active_d = active_q;
    end
    pal_d = pal_q;
    if (pal_we) begin
      pal_d[pal_addr] = pal_rgb;
    end else begin
      pal_d = pal_q;
    end
  end

  // Pixel datapath: priority winner, ROM address, then colour select.
  always_comb begin
    any_hit_s = |hit_s;
    win_s     = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      win_s = hit_s[i] ? SEL_W'(i) : win_s;
    end
    v1_d     = pix_valid_in;
    hit1_d   = any_hit_s;
    circ1_d  = any_hit_s && (active_q[win_s].kind == LK_CIRCLE);
    color1_d = color_s[win_s];
    if (any_hit_s && !circ1_d) begin
      tex_addr_d = {win_s, rel_y_s[win_s], rel_x_s[win_s]};
    end else begin
      tex_addr_d = '0;
    end
    v2_d        = v1_q;
    hit2_d      = hit1_q;
    circ2_d     = circ1_q;
    color2_d    = color1_q;
    idx_s       = circ2_q ? color2_q : tex_idx;
    valid_out_d = v2_q;
    if (!v2_q) begin
      rgb_d = rgb_q;
    end else if (hit2_q) begin
      rgb_d = pal_q[idx_s];
    end else begin
      rgb_d = bg_rgb;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      for (int i = 0; i < 2**IDX_W; i++) begin
        pal_q[i] <= 24'hFFFFFF;
      end
      v1_q        <= 1'b0;
      hit1_q      <= 1'b0;
      circ1_q     <= 1'b0;
      color1_q    <= '0;
      tex_addr_q  <= '0;
      v2_q        <= 1'b0;
      hit2_q      <= 1'b0;
      circ2_q     <= 1'b0;
      color2_q    <= '0;
      valid_out_q <= 1'b0;
      rgb_q       <= 24'h000000;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pal_q       <= pal_d;
      v1_q        <= v1_d;
      hit1_q      <= hit1_d;
      circ1_q     <= circ1_d;
      color1_q    <= color1_d;
      tex_addr_q  <= tex_addr_d;
      v2_q        <= v2_d;
      hit2_q      <= hit2_d;
      circ2_q     <= circ2_d;
      color2_q    <= color2_d;
      valid_out_q <= valid_out_d;
      rgb_q       <= rgb_d;
    end
  end

  assign tex_addr      = tex_addr_q;
  assign pix_valid_out = valid_out_q;
  assign Red           = rgb_q[23:16];
  assign Green         = rgb_q[15:8];
  assign Blue          = rgb_q[7:0];

`ifdef COMPOSITOR_COLLISION_EN
  logic [NUM_LAYERS-1:0] mask1_q, mask1_d, mask2_q, mask2_d;
  logic [NUM_LAYERS-1:0] hit_mask_q, hit_mask_d, collide_q, collide_d;

  // Raw hit mask follows the pixel; collision flags are sticky, set beats clear.
  always_comb begin
    mask1_d    = hit_s;
    mask2_d    = mask1_q;
    hit_mask_d = mask2_q;
    collide_d  = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      collide_d[i] = (v2_q && mask2_q[i] && ((mask2_q & ~(NUM_LAYERS'(1) << i)) != '0)) ||
                     (collide_q[i] && !frame_start);
    end
  end

  // Collision registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mask1_q    <= '0;
      mask2_q    <= '0;
      hit_mask_q <= '0;
      collide_q  <= '0;
    end else begin
      mask1_q    <= mask1_d;
      mask2_q    <= mask2_d;
      hit_mask_q <= hit_mask_d;
      collide_q  <= collide_d;
    end
  end

  assign hit_mask = hit_mask_q;
  assign collide  = collide_q;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: expected pixels are computed from an
// integer reference model when driven and compared when the DUT emits them.
module tb_sprite_compositor;

  logic        Clk = 1'b0;
  logic        Reset, frame_start, pix_valid_in;
  logic [9:0]  DrawX, DrawY;
  logic        cfg_we, cfg_en, cfg_kind;
  logic [1:0]  cfg_sel;
  logic [9:0]  cfg_x, cfg_y, cfg_w, cfg_h;
  logic [7:0]  cfg_color;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_rgb, bg_rgb;
  logic [11:0] tex_addr;
  logic [7:0]  tex_idx = 8'd0;
  logic        pix_valid_out;
  logic [7:0]  Red, Green, Blue;
`ifdef COMPOSITOR_COLLISION_EN
  logic [3:0]  hit_mask, collide;
`endif

  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid_in(pix_valid_in),
    .DrawX(DrawX), .DrawY(DrawY), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_en(cfg_en),
    .cfg_kind(cfg_kind), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_color(cfg_color), .pal_we(pal_we), .pal_addr(pal_addr), .pal_rgb(pal_rgb),
    .bg_rgb(bg_rgb), .tex_addr(tex_addr), .tex_idx(tex_idx), .pix_valid_out(pix_valid_out),
    .Red(Red), .Green(Green), .Blue(Blue)
`ifdef COMPOSITOR_COLLISION_EN
    , .hit_mask(hit_mask), .collide(collide)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] rom_f(input logic [11:0] a);
    if (a == 12'h54A) return 8'd5;
    return a[7:0] + 8'd17;
  endfunction

  // Texture ROM with one cycle of read latency.
  always @(posedge Clk) tex_idx <= rom_f(tex_addr);

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int stamp; int id; logic [23:0] rgb; logic [3:0] mask; } exp_t;
  exp_t sb [$];
  int n_cmp = 0, n_err = 0, pid = 0;

  int sh_en[4], sh_kind[4], sh_x[4], sh_y[4], sh_w[4], sh_h[4], sh_col[4];
  int ac_en[4], ac_kind[4], ac_x[4], ac_y[4], ac_w[4], ac_h[4], ac_col[4];
  logic [23:0] mpal [256];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      sh_en[i] = 0; sh_kind[i] = 0; sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0; sh_col[i] = 0;
      ac_en[i] = 0; ac_kind[i] = 0; ac_x[i] = 0; ac_y[i] = 0; ac_w[i] = 0; ac_h[i] = 0; ac_col[i] = 0;
    end
    for (int i = 0; i < 256; i++) mpal[i] = 24'hFFFFFF;
  endtask

  task automatic model_copy();
    ac_en = sh_en; ac_kind = sh_kind; ac_x = sh_x; ac_y = sh_y;
    ac_w = sh_w; ac_h = sh_h; ac_col = sh_col;
  endtask

  task automatic model_pix(input int px, input int py, output logic [23:0] rgb,
                           output logic [11:0] tex, output logic [3:0] mask);
    int win;
    bit h;
    win = -1; mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (ac_en[i] != 0) begin
        if (ac_kind[i] == 0)
          h = (px >= ac_x[i]) && (px < ac_x[i] + ac_w[i]) && (py >= ac_y[i]) && (py < ac_y[i] + ac_h[i]);
        else
          h = ((px - ac_x[i]) * (px - ac_x[i]) + (py - ac_y[i]) * (py - ac_y[i])) <= ac_w[i] * ac_w[i];
        if (h) begin
          mask[i] = 1'b1;
          if (win < 0) win = i;
        end
      end
    end
    if (win < 0) begin
      tex = 12'h000; rgb = bg_rgb;
    end else if (ac_kind[win] == 0) begin
      tex = 12'((win << 10) | (((py - ac_y[win]) & 31) << 5) | ((px - ac_x[win]) & 31));
      rgb = mpal[rom_f(tex)];
    end else begin
      tex = 12'h000; rgb = mpal[ac_col[win]];
    end
  endtask

  task automatic pix(input int px, input int py);
    exp_t e;
    logic [11:0] et;
    model_pix(px, py, e.rgb, et, e.mask);
    e.stamp = cyc; e.id = pid; pid++;
    sb.push_back(e);
    DrawX = 10'(px); DrawY = 10'(py); pix_valid_in = 1'b1;
    @(negedge Clk);
    pix_valid_in = 1'b0;
    check_val($sformatf("tex_addr%0d(%0d,%0d)", e.id, px, py), {20'd0, tex_addr}, {20'd0, et});
  endtask

  task automatic cfg_write(input int sel, input int en, input int kind, input int x, input int y,
                           input int w, input int h, input int col, input bit fs);
    cfg_sel = 2'(sel); cfg_en = 1'(en); cfg_kind = 1'(kind); cfg_x = 10'(x); cfg_y = 10'(y);
    cfg_w = 10'(w); cfg_h = 10'(h); cfg_color = 8'(col); cfg_we = 1'b1; frame_start = fs;
    sh_en[sel] = en; sh_kind[sel] = kind; sh_x[sel] = x; sh_y[sel] = y;
    sh_w[sel] = w; sh_h[sel] = h; sh_col[sel] = col;
    if (fs) model_copy();
    @(negedge Clk);
    cfg_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    model_copy();
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic pal_write(input int a, input logic [23:0] v);
    pal_addr = 8'(a); pal_rgb = v; pal_we = 1'b1;
    mpal[a] = v;
    @(negedge Clk);
    pal_we = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge Clk);
      k++;
    end
    check_val("drain", sb.size(), 0);
  endtask

  // Output monitor: pop one expectation per valid pixel and check latency and colour.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (pix_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          check_val("spurious_valid", {31'd0, pix_valid_out}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val($sformatf("latency%0d", e.id), cyc - e.stamp, 3);
          check_val($sformatf("rgb%0d", e.id), {8'h00, Red, Green, Blue}, {8'h00, e.rgb});
`ifdef COMPOSITOR_COLLISION_EN
          check_val($sformatf("hit_mask%0d", e.id), {28'd0, hit_mask}, {28'd0, e.mask});
`endif
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    Reset = 1'b1; frame_start = 1'b0; pix_valid_in = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_en = 1'b0; cfg_kind = 1'b0; cfg_x = 10'd0; cfg_y = 10'd0;
    cfg_w = 10'd0; cfg_h = 10'd0; cfg_color = 8'd0; pal_we = 1'b0; pal_addr = 8'd0;
    pal_rgb = 24'd0; bg_rgb = 24'h0A0B0C;
    model_reset();
    repeat (3) @(negedge Clk);
    check_val("rst_valid", {31'd0, pix_valid_out}, 32'd0);
    check_val("rst_rgb", {8'h00, Red, Green, Blue}, 32'd0);
    check_val("rst_tex", {20'd0, tex_addr}, 32'd0);
    Reset = 1'b0;

    pix(100, 100); pix(101, 100);
    drain();

    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      pal_write(i, {b, ~b, b ^ 8'h5A});
    end
    pal_write(5, 24'h123456);
    pal_write(7, 24'hABCDEF);

    cfg_write(1, 1, 0, 50, 50, 32, 32, 0, 1'b0);
    pix(60, 60);
    drain();
    frame();
    pix(60, 60);
    drain();

    cfg_write(0, 1, 1, 60, 60, 5, 0, 7, 1'b0);
    frame();
    pix(63, 64); pix(64, 64); pix(60, 60);
    pix(81, 60); pix(82, 60); pix(50, 50); pix(49, 50); pix(60, 81); pix(60, 82);
    drain();

    cfg_write(2, 1, 0, 1020, 0, 10, 10, 0, 1'b0);
    frame();
    pix(1023, 5); pix(0, 5); pix(3, 5); pix(1019, 5);
    drain();

    cfg_write(3, 1, 1, 5, 5, 10, 0, 9, 1'b1);
    pix(0, 0); pix(16, 5); pix(15, 5);
    drain();

    cfg_write(2, 1, 0, 1020, 0, 0, 10, 0, 1'b0);
    frame();
    pix(1020, 5); pix(1023, 5);
    for (int i = 0; i < 40; i++) pix($urandom_range(90, 40), $urandom_range(90, 40));
    drain();

    pix(60, 60); pix(61, 61); pix(62, 62);
    Reset = 1'b1;
    sb.delete();
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    pix(60, 60);
    check_val("flush_a", {31'd0, pix_valid_out}, 32'd0);
    @(negedge Clk);
    check_val("flush_b", {31'd0, pix_valid_out}, 32'd0);
    drain();

`ifdef COMPOSITOR_COLLISION_EN
    cfg_write(0, 1, 1, 60, 60, 5, 0, 7, 1'b0);
    cfg_write(2, 1, 0, 55, 55, 10, 10, 0, 1'b0);
    frame();
    check_val("collide_idle", {28'd0, collide}, 32'd0);
    pix(60, 60);
    drain();
    check_val("collide_set", {28'd0, collide}, 32'h5);
    pix(56, 56);
    drain();
    check_val("collide_sticky", {28'd0, collide}, 32'h5);
    frame();
    check_val("collide_clr", {28'd0, collide}, 32'd0);
`endif

    repeat (4) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
